// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into a 32-bit word and flags unrepresentable immediates.
// Latency: one cycle from accepted request to out_valid (FIFO write then read).
// Backpressure: in_ready = !full, registered only; out_ready never reaches in_ready combinationally.
module instr_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  input  logic        stats_clr,
  output logic [15:0] enc_count,
  output logic [15:0] err_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic [31:0]   enc_instr;
  logic          enc_err;
  logic [32:0]   mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && !full;
  assign pop       = !empty && out_ready;
  assign out_instr = mem[rptr][31:0];
  assign out_err   = mem[rptr][32];

  // Field packing and representability check; invalid formats fall back to NOP with err.
  always_comb begin
    enc_instr = NOP_WORD;
    enc_err   = 1'b1;
    case (in_fmt)
      FMT_I: begin
        enc_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_S: begin
        enc_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err   = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      end
      FMT_B: begin
        enc_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], in_opcode};
        enc_err   = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
      end
      FMT_U: begin
        enc_instr = {in_imm[31:12], in_rd, in_opcode};
        enc_err   = |in_imm[11:0];
      end
      FMT_J: begin
        enc_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err   = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
      end
      FMT_R: begin
        enc_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        enc_err   = 1'b0;
      end
      default: begin
        enc_instr = NOP_WORD;
        enc_err   = 1'b1;
      end
    endcase
  end

  // Entry storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wptr] <= {enc_err, enc_instr};
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (stats_clr) begin
      enc_count <= '0;
      err_count <= '0;
    end else if (push) begin
      if (enc_count != 16'hFFFF) begin
        enc_count <= enc_count + 16'd1;
      end
      if (enc_err && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] ins;
    logic        err;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic        stats_clr = 1'b0;
  logic [15:0] enc_count;
  logic [15:0] err_count;

  int nvec = 0;
  int nerr = 0;
  logic [32:0] sbq [$];

  instr_encoder #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .stats_clr(stats_clr), .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Drive one request and record what the encoder should produce for it.
  task automatic drive_req(input req_t r);
    in_fmt    = r.fmt;
    in_opcode = r.op;
    in_rd     = r.rd;
    in_rs1    = r.rs1;
    in_rs2    = r.rs2;
    in_funct3 = r.f3;
    in_funct7 = r.f7;
    in_imm    = r.imm;
    in_valid  = 1'b1;
    sbq.push_back({r.err, r.ins});
  endtask

  task automatic test_reset();
    #3;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    nvec++; if ({out_err, out_instr} !== 33'h0) begin nerr++; $display("FAIL rst_out_word: got %h expected 0", {out_err, out_instr}); end
    nvec++; if ({enc_count, err_count} !== 32'h0) begin nerr++; $display("FAIL rst_counters: got %h expected 0", {enc_count, err_count}); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_encode();
    req_t tbl [6];
    logic [32:0] exp;
    tbl[0] = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 1'b0};
    tbl[1] = '{3'd1, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 1'b0};
    tbl[2] = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    tbl[3] = '{3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0};
    tbl[4] = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0};
    tbl[5] = '{3'd5, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,       32'h402081B3, 1'b0};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive_req(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      exp = sbq.pop_front();
      nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL enc_latency[%0d]: got out_valid=%b expected 1", i, out_valid); end
      nvec++; if ({out_err, out_instr} !== exp) begin nerr++; $display("FAIL enc_word[%0d]: got %h expected %h", i, {out_err, out_instr}, exp); end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL enc_drained[%0d]: got %b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_errors();
    req_t tbl [7];
    logic [32:0] exp;
    tbl[0] = '{3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1};
    tbl[1] = '{3'd6, 7'h33, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0,        32'h00000013, 1'b1};
    tbl[2] = '{3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h80000013, 1'b0};
    tbl[3] = '{3'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000013, 1'b1};
    tbl[4] = '{3'd2, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000003, 32'h00000163, 1'b1};
    tbl[5] = '{3'd4, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000, 32'h8000006F, 1'b1};
    tbl[6] = '{3'd1, 7'h23, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFE000FA3, 1'b0};
    @(negedge clk);
    stats_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stats_clr = 1'b0;
    nvec++; if (enc_count !== 16'd0) begin nerr++; $display("FAIL clr_enc: got %0d expected 0", enc_count); end
    for (int i = 0; i < 7; i++) begin
      out_ready = 1'b0;
      drive_req(tbl[i]);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      exp = sbq.pop_front();
      nvec++; if ({out_valid, out_err, out_instr} !== {1'b1, exp}) begin nerr++; $display("FAIL err_word[%0d]: got %b/%h expected 1/%h", i, out_valid, {out_err, out_instr}, exp); end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      if (i == 1) begin
        nvec++; if ({enc_count, err_count} !== {16'd2, 16'd2}) begin nerr++; $display("FAIL err_counts_2: got enc=%0d err=%0d expected 2/2", enc_count, err_count); end
      end
    end
    nvec++; if ({enc_count, err_count} !== {16'd7, 16'd5}) begin nerr++; $display("FAIL err_counts_7: got enc=%0d err=%0d expected 7/5", enc_count, err_count); end
  endtask

  task automatic test_backpressure();
    logic [31:0] words [5];
    logic [32:0] exp;
    logic acc;
    req_t r;
    words[0] = 32'h00100093; words[1] = 32'h00200113; words[2] = 32'h00300193;
    words[3] = 32'h00400213; words[4] = 32'h00500293;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r = '{3'd0, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i + 1), words[i], 1'b0};
      nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready[%0d]: got %b expected 1", i, in_ready); end
      drive_req(r);
      @(posedge clk);
      @(negedge clk);
    end
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_full: got in_ready=%b expected 0", in_ready); end
    r = '{3'd0, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, words[4], 1'b0};
    drive_req(r);
    @(posedge clk);
    @(negedge clk);
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bp_held: got in_ready=%b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (sbq.size() == 0) break;
      exp = sbq.pop_front();
      nvec++; if ({out_valid, out_err, out_instr} !== {1'b1, exp}) begin nerr++; $display("FAIL bp_order[%0d]: got %b/%h expected 1/%h", c, out_valid, {out_err, out_instr}, exp); end
      if (c == 1) begin
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bp_ready_after_pop: got %b expected 1", in_ready); end
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    nvec++; if ({in_valid, out_valid} !== 2'b00) begin nerr++; $display("FAIL bp_done: got valid_in/out=%b expected 00", {in_valid, out_valid}); end
    nvec++; if ({enc_count, err_count} !== {16'd12, 16'd5}) begin nerr++; $display("FAIL bp_counts: got enc=%0d err=%0d expected 12/5", enc_count, err_count); end
  endtask

  task automatic test_back_to_back();
    req_t r;
    logic [32:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        exp = sbq.pop_front();
        nvec++; if ({out_valid, out_err, out_instr} !== {1'b1, exp}) begin nerr++; $display("FAIL b2b[%0d]: got %b/%h expected 1/%h", k - 1, out_valid, {out_err, out_instr}, exp); end
      end
      if (k < 8) begin
        r.fmt = 3'd5; r.op = 7'h33;
        r.rd  = 5'($urandom_range(31)); r.rs1 = 5'($urandom_range(31)); r.rs2 = 5'($urandom_range(31));
        r.f3  = 3'($urandom_range(7));  r.f7  = 7'($urandom_range(127)); r.imm = $urandom;
        r.ins = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
        r.err = 1'b0;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready); end
        drive_req(r);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    nvec++; if ({enc_count, err_count} !== {16'd20, 16'd5}) begin nerr++; $display("FAIL b2b_counts: got enc=%0d err=%0d expected 20/5", enc_count, err_count); end
  endtask

  task automatic test_reset_midstream();
    req_t r;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = '{3'd3, 7'h37, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 32'h00001037 | (32'(i) << 7), 1'b0};
      drive_req(r);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mid_buffered: got %b expected 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    sbq.delete();
    nvec++; if ({out_valid, in_ready} !== 2'b01) begin nerr++; $display("FAIL mid_rst_flags: got valid/ready=%b expected 01", {out_valid, in_ready}); end
    nvec++; if ({enc_count, err_count} !== 32'h0) begin nerr++; $display("FAIL mid_rst_counters: got %h expected 0", {enc_count, err_count}); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_no_output: got %b expected 0", out_valid); end
  endtask

  task automatic test_stats_clr();
    req_t ok_r;
    req_t bad_r;
    logic [32:0] exp;
    ok_r  = '{3'd0, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,        32'h00500093, 1'b0};
    bad_r = '{3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345001, 32'h123452B7, 1'b1};
    out_ready = 1'b1;
    drive_req(bad_r);
    @(posedge clk);
    @(negedge clk);
    exp = sbq.pop_front();
    nvec++; if ({out_valid, out_err, out_instr} !== {1'b1, exp}) begin nerr++; $display("FAIL clr_pre_word: got %b/%h expected 1/%h", out_valid, {out_err, out_instr}, exp); end
    drive_req(ok_r);
    stats_clr = 1'b1;
    nvec++; if ({enc_count, err_count} !== {16'd1, 16'd1}) begin nerr++; $display("FAIL clr_pre_counts: got enc=%0d err=%0d expected 1/1", enc_count, err_count); end
    @(posedge clk);
    @(negedge clk);
    stats_clr = 1'b0;
    in_valid = 1'b0;
    exp = sbq.pop_front();
    nvec++; if ({enc_count, err_count} !== 32'h0) begin nerr++; $display("FAIL clr_priority: got enc=%0d err=%0d expected 0/0", enc_count, err_count); end
    nvec++; if ({out_valid, out_err, out_instr} !== {1'b1, exp}) begin nerr++; $display("FAIL clr_word: got %b/%h expected 1/%h", out_valid, {out_err, out_instr}, exp); end
    drive_req(bad_r);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    exp = sbq.pop_front();
    nvec++; if ({out_valid, out_err, out_instr} !== {1'b1, exp}) begin nerr++; $display("FAIL clr_post_word: got %b/%h expected 1/%h", out_valid, {out_err, out_instr}, exp); end
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    nvec++; if ({enc_count, err_count} !== {16'd1, 16'd1}) begin nerr++; $display("FAIL clr_resume: got enc=%0d err=%0d expected 1/1", enc_count, err_count); end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_errors();
    @(negedge clk);
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    @(negedge clk);
    test_stats_clr();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder for the decode-side test and debug path. It takes decoded instruction fields and packs them into a 32-bit RV32I instruction word. It uses the same format codes as the decoder's immediate generator, so re-extracting the immediate from the output with the same format returns the input immediate. Requests arrive on a valid/ready handshake, and results are buffered in an output FIFO. The block flags immediates that the chosen format cannot represent and keeps saturating statistics counters.

## Interface
- DEPTH, 4, output FIFO entries; power of two, 2 to 16.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_fmt  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101 R; 110/111 invalid.
- in_opcode  in  7  instr[6:0].
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  instr[14:12].
- in_funct7  in  7  instr[31:25]; R only.
- in_imm  in  32  immediate, byte offset, sign-extended.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  head consumed when out_valid && out_ready.
- out_instr  out  32  encoded word at head.
- out_err  out  1  head entry's immediate was unrepresentable or its format invalid.
- stats_clr  in  1  synchronous clear of both counters.
- enc_count  out  16  accepted requests, saturating at 0xFFFF.
- err_count  out  16  accepted requests with err, saturating at 0xFFFF.

## Operation
- Encoding per format. Fields not listed below are zero.
  - I: imm[11:0] at [31:20], rs1 [19:15], funct3, rd [11:7], opcode.
  - S: imm[11:5] at [31:25], rs2 [24:20], rs1, funct3, imm[4:0] at [11:7], opcode.
  - B: imm[12] at [31], imm[10:5] at [30:25], rs2, rs1, funct3, imm[4:1] at [11:8], imm[11] at [7], opcode.
  - U: imm[31:12] at [31:12], rd, opcode.
  - J: imm[20] at [31], imm[10:1] at [30:21], imm[11] at [20], imm[19:12] at [19:12], rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode; in_imm ignored.
- Error rules. The word is still emitted with truncated fields, and err=1.
  - I/S: imm[31:11] not all equal.
  - B: imm[31:12] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - R: never an error.
  - Invalid fmt: word forced to 32'h00000013 (NOP), err=1.
- Encoding and the error check are combinational from the inputs. The {instr, err} pair is written into the FIFO on an accepted request.
- FIFO behaviour:
  - Circular buffer with read/write pointers and an occupancy count of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
  - in_ready = !full. There is no combinational path from out_ready to in_ready.
  - out_valid = !empty. out_instr and out_err come from the entry at the read pointer and are held stable while out_valid && !out_ready.
  - Push and pop in the same cycle: both pointers advance and the count is unchanged.
  - When full, no push is accepted, even if a pop happens that cycle.
- Counters:
  - enc_count increments on each accepted request. err_count also increments if that request has err=1.
  - Both saturate at 0xFFFF.
  - stats_clr has priority over an increment in the same cycle, so the result is 0.

## Timing
- Reset, asynchronous and immediate on assertion: pointers and count go to 0. in_ready=1, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0.
- Latency: a request accepted at edge N, with the FIFO empty, shows out_valid=1 after edge N.
- Throughput: one request per cycle while out_ready=1 continuously.
- Full: after DEPTH accepts with no pop, in_ready=0 after the final edge. in_ready returns to 1 after the first pop edge.
- Reset mid-operation: all buffered entries are discarded and counters clear. No output is emitted until a new request is accepted.

## Test plan
- addi x1,x0,5: I, op 0x13, rd=1, imm=5. Expect out_instr=0x00500093, err=0, one cycle after acceptance.
- sw x2,8(x1): S, op 0x23, funct3=2, rs1=1, rs2=2, imm=8. Expect 0x0020A423.
- beq x0,x0,-4: B, op 0x63, imm=0xFFFFFFFC. Expect 0xFE000EE3.
- jal x1,0x800: J, op 0x6F, rd=1. Expect 0x001000EF.
- Error cases:
  - U with imm=0x12345001: err=1, out_instr[31:12]=0x12345.
  - fmt=110: out_instr=0x00000013, err=1.
  - err_count=2 and enc_count=2 after these two.
- Backpressure, DEPTH=4, out_ready=0:
  - Send 5 requests: in_ready drops after the 4th accept and the 5th is held.
  - Raise out_ready: words drain in order, and the 5th is accepted after the first pop.
- Mid-stream checks:
  - Pulse rst with 3 entries buffered: out_valid=0 and counters=0 immediately.
  - Assert stats_clr together with an accepted request: both counters are 0 next cycle.
